id_hazard_scoreboard: RTL and testbench

//   Parametrised load-use/multi-cycle hazard detector for the ID stage; successor to the single-compare

---
 rtl/id_hazard_scoreboard.sv | 90 +++++++++
 tb/tb_id_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// Purpose: ID-stage RAW hazard scoreboard; per-register countdown until a pending result is forwardable.
// Latency: Stall is combinational from registered countdowns; issue updates take effect the next cycle.
// Backpressure: Stall holds PC/IF-ID and IFWrite=~Stall; an issue presented while stalled is ignored.
module id_hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1Addr_id,
    input  logic [ADDR_W-1:0] rs2Addr_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              issue_valid,
    input  logic              issue_regwrite,
    input  logic [ADDR_W-1:0] rdAddr_id,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic              perf_clr,
    output logic              Stall,
    output logic              IFWrite,
    output logic [NREG-1:0]   busy_vec,
    output logic [CNT_W-1:0]  stall_cycles
);

    // x0 is hardwired zero, so it has no countdown storage at all.
    logic [LAT_W-1:0] cnt_q [1:NREG-1];
    logic [LAT_W-1:0] cnt_d [1:NREG-1];

    logic rs1_pend;
    logic rs2_pend;
    logic fire;

    // Busy flags per register; bit 0 stays clear because x0 is never pending.
    always_comb begin
        busy_vec    = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    // Source lookup by comparison so addresses at or beyond NREG simply never match.
    always_comb begin
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (rs1Addr_id == ADDR_W'(r) && busy_vec[r]) rs1_pend = 1'b1;
            if (rs2Addr_id == ADDR_W'(r) && busy_vec[r]) rs2_pend = 1'b1;
        end
    end

    // Stall only depends on registered state and source addresses, never on issue_*.
    always_comb begin
        Stall   = (rs1_used & rs1_pend) | (rs2_used & rs2_pend);
        IFWrite = ~Stall;
        fire    = issue_valid & ~Stall;
    end

    // Next countdown: decrement toward zero, and on a write keep the longer of old and new latency
    // so an older slow write to the same register is not masked by a younger fast one.
    always_comb begin
        logic [LAT_W-1:0] dec;
        for (int r = 1; r < NREG; r++) begin
            dec      = (cnt_q[r] == '0) ? '0 : cnt_q[r] - 1'b1;
            cnt_d[r] = dec;
            if (fire && issue_regwrite && rdAddr_id == ADDR_W'(r)) begin
                cnt_d[r] = (issue_lat > dec) ? issue_lat : dec;
            end
        end
    end

    // Countdown registers; reset wins over any issue in the same cycle.
    always_ff @(posedge clk) begin
        for (int r = 1; r < NREG; r++) begin
            if (reset) cnt_q[r] <= '0;
            else       cnt_q[r] <= cnt_d[r];
        end
    end

    // Saturating stall-cycle counter; clear takes priority over counting.
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            stall_cycles <= '0;
        end else if (Stall && stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;

    localparam int NREG   = 24;
    localparam int ADDR_W = 5;
    localparam int LAT_W  = 3;
    localparam int CNT_W  = 6;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rs1Addr_id, rs2Addr_id, rdAddr_id;
    logic              rs1_used, rs2_used, issue_valid, issue_regwrite, perf_clr;
    logic [LAT_W-1:0]  issue_lat;
    logic              Stall, IFWrite;
    logic [NREG-1:0]   busy_vec;
    logic [CNT_W-1:0]  stall_cycles;

    id_hazard_scoreboard #(.NREG(NREG), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
        .rdAddr_id(rdAddr_id), .issue_lat(issue_lat), .perf_clr(perf_clr),
        .Stall(Stall), .IFWrite(IFWrite), .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle at which each register's result becomes forwardable.
    int ready_at [NREG];
    int cyc;
    int m_sc;
    logic obs_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit pend(input int a);
        return (a != 0) && (a < NREG) && (ready_at[a] > cyc);
    endfunction

    function automatic logic [NREG-1:0] exp_busy();
        logic [NREG-1:0] b = '0;
        for (int r = 1; r < NREG; r++) b[r] = (ready_at[r] > cyc);
        return b;
    endfunction

    task automatic drive(input int r1, input bit u1, input int r2, input bit u2,
                         input bit v, input bit w, input int rd, input int lat);
        rs1Addr_id     = ADDR_W'(r1);
        rs1_used       = u1;
        rs2Addr_id     = ADDR_W'(r2);
        rs2_used       = u2;
        issue_valid    = v;
        issue_regwrite = w;
        rdAddr_id      = ADDR_W'(rd);
        issue_lat      = LAT_W'(lat);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model across the edge.
    task automatic step();
        bit es;
        int rd;
        @(negedge clk);
        es = (rs1_used && pend(int'(rs1Addr_id))) || (rs2_used && pend(int'(rs2Addr_id)));
        obs_stall = Stall;
        chk("stall", 64'(Stall), 64'(es));
        chk("ifwrite", 64'(IFWrite), 64'(!es));
        chk("busy_vec", 64'(busy_vec), 64'(exp_busy()));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_sc));
        if (reset) begin
            for (int r = 0; r < NREG; r++) ready_at[r] = 0;
            m_sc = 0;
        end else begin
            rd = int'(rdAddr_id);
            if (issue_valid && !es && issue_regwrite && rd != 0 && rd < NREG) begin
                if (cyc + int'(issue_lat) + 1 > ready_at[rd]) ready_at[rd] = cyc + int'(issue_lat) + 1;
            end
            if (perf_clr) m_sc = 0;
            else if (es && m_sc < SAT) m_sc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold the current instruction in ID until it issues; return how many cycles it stalled.
    task automatic run_until_issue(output int n);
        bit done = 0;
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (obs_stall) n++;
            else done = 1;
        end
        if (!done) chk("issue_timeout", 64'(n), 64'(0));
        idle();
    endtask

    int n;

    initial begin
        cyc = 0;
        m_sc = 0;
        obs_stall = 0;
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        reset = 1'b1;
        perf_clr = 1'b0;
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        step();
        reset = 1'b0;
        step();

        // Load-use: one bubble
        drive(0, 0, 0, 0, 1, 1, 5, 1); step();
        drive(5, 1, 7, 1, 1, 1, 6, 0); run_until_issue(n);
        chk("t1_stall_len", 64'(n), 64'(1));
        chk("t1_stall_cycles", 64'(stall_cycles), 64'(1));

        // Multi-cycle via rs2
        drive(0, 0, 0, 0, 1, 1, 8, 4); step();
        drive(3, 1, 8, 1, 1, 0, 0, 0); run_until_issue(n);
        chk("t2_stall_len", 64'(n), 64'(4));
        chk("t2_busy8", 64'(busy_vec[8]), 64'(0));

        // x0 writes and zero-latency writes never stall
        drive(0, 0, 0, 0, 1, 1, 0, 3); step();
        drive(0, 1, 0, 1, 1, 0, 0, 0); run_until_issue(n);
        chk("t3_x0_len", 64'(n), 64'(0));
        drive(0, 0, 0, 0, 1, 1, 9, 0); step();
        drive(9, 1, 9, 1, 1, 0, 0, 0); run_until_issue(n);
        chk("t3_alu_len", 64'(n), 64'(0));

        // WAW keeps the longer pending latency
        drive(0, 0, 0, 0, 1, 1, 10, 5); step();
        drive(0, 0, 0, 0, 1, 1, 10, 1); step();
        drive(10, 1, 0, 0, 1, 0, 0, 0); run_until_issue(n);
        chk("t4_waw_len", 64'(n), 64'(4));

        // Unused source does not stall; issue while stalled is ignored
        drive(0, 0, 0, 0, 1, 1, 5, 3); step();
        drive(5, 0, 0, 0, 1, 0, 0, 0); step();
        chk("t5_unused", 64'(obs_stall), 64'(0));
        drive(5, 1, 0, 0, 1, 1, 13, 7); step();
        chk("t5_busy13_held", 64'(busy_vec[13]), 64'(0));
        run_until_issue(n);
        chk("t5_busy13_set", 64'(busy_vec[13]), 64'(1));
        for (int i = 0; i < 8; i++) step();

        // Reset mid-countdown
        drive(0, 0, 0, 0, 1, 1, 12, 3); step();
        drive(12, 1, 0, 0, 1, 0, 0, 0);
        reset = 1'b1; perf_clr = 1'b0; step();
        reset = 1'b0; step();
        chk("t6_rst_stall", 64'(obs_stall), 64'(0));
        idle();

        // Saturation of the stall counter, then clear while stalling
        for (int k = 0; k < 12; k++) begin
            drive(0, 0, 0, 0, 1, 1, 14, 7); step();
            drive(14, 1, 0, 0, 1, 0, 0, 0); run_until_issue(n);
        end
        chk("t6_sat", 64'(stall_cycles), 64'(SAT));
        drive(0, 0, 0, 0, 1, 1, 14, 7); step();
        drive(14, 1, 0, 0, 1, 0, 0, 0); step(); step();
        chk("t6_sat_hold", 64'(stall_cycles), 64'(SAT));
        perf_clr = 1'b1; step();
        perf_clr = 1'b0;
        chk("t6_clr", 64'(stall_cycles), 64'(0));
        for (int i = 0; i < 8; i++) step();

        // Randomized traffic, including out-of-range addresses and occasional reset/clear
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 31), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31), $urandom_range(0, 7));
            reset    = ($urandom_range(0, 199) == 0);
            perf_clr = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        perf_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
